// File: rtl/instruction_memory_pkg.sv
// Shared constants for the RV32I instruction memory: geometry, the NOP filler
// word and the default program image restored by reset.
package im_pkg;

    localparam int          DEPTH    = 64;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int          PROG_LEN = 8;

    localparam logic [31:0] DEFAULT_PROG [PROG_LEN] = '{
        32'h0050_0093,
        32'h00A0_0113,
        32'h0020_81B3,
        32'h4011_0233,
        32'h0020_F2B3,
        32'h0020_E333,
        32'h0030_2023,
        32'h0000_0063
    };

    // Words beyond the short default program are padded with NOPs.
    function automatic logic [31:0] defaultWord(input int idx);
        logic [2:0] progIdx;
        progIdx = idx[2:0];
        if (idx < PROG_LEN)
            return DEFAULT_PROG[progIdx];
        return NOP_WORD;
    endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch and program-port bundle between a core/loader (master) and the
// instruction memory (slave).
interface instruction_memory_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instruction;
    logic              misaligned;
    logic              out_of_range;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output address, we, waddr, wdata,
        input  instruction, misaligned, out_of_range
    );

    modport slave (
        input  address, we, waddr, wdata,
        output instruction, misaligned, out_of_range
    );

endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory with a combinational fetch port, a clocked
// program port and an asynchronous reset that reloads the default image.
module instruction_memory
    import im_pkg::*;
#(
    parameter int          P_DEPTH    = im_pkg::DEPTH,
    parameter int          P_ADDR_W   = im_pkg::ADDR_W,
    parameter int          P_DATA_W   = im_pkg::DATA_W,
    parameter logic [31:0] P_NOP_WORD = im_pkg::NOP_WORD
) (
    input logic                 clk,
    input logic                 rst,
    instruction_memory_if.slave bus
);

    localparam int IDX_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [P_DATA_W-1:0] r_mem [P_DEPTH];

    logic [P_ADDR_W-3:0] w_rdIdx;
    logic [P_ADDR_W-3:0] w_wrIdx;
    logic                w_rdInRange;
    logic                w_wrOk;

    assign w_rdIdx     = bus.address[P_ADDR_W-1:2];
    assign w_wrIdx     = bus.waddr[P_ADDR_W-1:2];
    assign w_rdInRange = (w_rdIdx < (P_ADDR_W-2)'(P_DEPTH));
    assign w_wrOk      = bus.we && (bus.waddr[1:0] == 2'b00)
                         && (w_wrIdx < (P_ADDR_W-2)'(P_DEPTH));

    // Reset holds the whole array at the default image, so writes cannot land
    // while rst is high; otherwise only aligned in-range writes take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P_DEPTH; i++)
                r_mem[i] <= P_DATA_W'(defaultWord(i));
        end else if (w_wrOk) begin
            r_mem[w_wrIdx[IDX_W-1:0]] <= bus.wdata;
        end
    end

    // Unmapped indices never alias into the array; they fetch a NOP.
    always_comb begin
        bus.instruction = P_DATA_W'(P_NOP_WORD);
        if (w_rdInRange)
            bus.instruction = r_mem[w_rdIdx[IDX_W-1:0]];
    end

    assign bus.misaligned   = (bus.address[1:0] != 2'b00);
    assign bus.out_of_range = !w_rdInRange;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench: directed fetch/write/reset cases followed by random
// traffic compared against a word-array reference model.
module tb_instruction_memory;
    import im_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          MDEPTH = 64;

    logic clk;
    logic rst;

    instruction_memory_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instruction_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [MDEPTH];
    logic [31:0] bootImage [8];

    // Model reset: default program followed by NOP padding.
    task automatic modelReset();
        bootImage[0] = 32'h0050_0093;
        bootImage[1] = 32'h00A0_0113;
        bootImage[2] = 32'h0020_81B3;
        bootImage[3] = 32'h4011_0233;
        bootImage[4] = 32'h0020_F2B3;
        bootImage[5] = 32'h0020_E333;
        bootImage[6] = 32'h0030_2023;
        bootImage[7] = 32'h0000_0063;
        for (int i = 0; i < MDEPTH; i++)
            model[i] = (i < 8) ? bootImage[i] : NOP;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx < MDEPTH)
            return model[idx];
        return NOP;
    endfunction

    task automatic modelWrite(input logic we, input logic [31:0] wa, input logic [31:0] wd);
        logic [31:0] idx;
        idx = wa >> 2;
        if (we && (wa % 4 == 0) && idx < MDEPTH)
            model[idx] = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                 input logic [31:0] wa, input logic [31:0] wd);
        bus.address = addr;
        bus.we      = we;
        bus.waddr   = wa;
        bus.wdata   = wd;
    endtask

    task automatic checkFetch(input string tag);
        logic [31:0] a;
        a = bus.address;
        checkOutput({tag, ".instr"}, bus.instruction, modelRead(a));
        checkOutput({tag, ".misal"}, {31'd0, bus.misaligned}, {31'd0, (a % 4) != 0});
        checkOutput({tag, ".oor"}, {31'd0, bus.out_of_range}, {31'd0, (a >> 2) >= MDEPTH});
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, MDEPTH - 1)) << 2;
            1: return 32'($urandom_range(0, MDEPTH * 4 - 1));
            2: return $urandom;
            default: return 32'($urandom_range(MDEPTH * 4 - 8, MDEPTH * 4 + 8));
        endcase
    endfunction

    initial begin
        logic [31:0] a, wa, wd;
        logic        w;

        rst = 1'b0;
        applyStimulus(32'd0, 1'b0, 32'd0, 32'd0);
        modelReset();
        #2 rst = 1'b1;
        #1;
        checkFetch("reset_hold");
        #10 rst = 1'b0;

        // Default image sweep at 10 ns steps.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'(i * 4), 1'b0, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("boot_w%0d", i), bus.instruction, bootImage[i]);
            checkFetch($sformatf("boot_sweep%0d", i));
            #9;
        end

        applyStimulus(32'd32, 1'b0, 32'd0, 32'd0);            #1; checkFetch("addr32");
        applyStimulus(32'd256, 1'b0, 32'd0, 32'd0);           #1; checkFetch("addr256");
        checkOutput("addr256.nop", bus.instruction, NOP);
        applyStimulus(32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0);     #1; checkFetch("addrTop");
        checkOutput("addrTop.oor1", {31'd0, bus.out_of_range}, 32'd1);
        applyStimulus(32'd9, 1'b0, 32'd0, 32'd0);             #1; checkFetch("addr9");
        checkOutput("addr9.val", bus.instruction, 32'h0020_81B3);

        // Read-during-write on word 2.
        @(posedge clk); #1;
        applyStimulus(32'd8, 1'b1, 32'd8, 32'hDEAD_BEEF);
        #1;
        checkOutput("rdw.before", bus.instruction, 32'h0020_81B3);
        @(posedge clk); #1;
        modelWrite(1'b1, 32'd8, 32'hDEAD_BEEF);
        checkOutput("rdw.after", bus.instruction, 32'hDEAD_BEEF);

        // Dropped writes: misaligned and out of range.
        applyStimulus(32'd8, 1'b1, 32'd10, 32'h1111_1111);
        @(posedge clk); #1;
        checkOutput("drop.misal", bus.instruction, 32'hDEAD_BEEF);
        applyStimulus(32'd256, 1'b1, 32'd256, 32'h2222_2222);
        @(posedge clk); #1;
        checkOutput("drop.oor", bus.instruction, NOP);
        bus.we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.address = 32'(i * 4);
            #1;
            checkFetch($sformatf("drop_sweep%0d", i));
        end

        // Mid-cycle async reset with a write attempted during reset.
        @(posedge clk); #3;
        applyStimulus(32'd8, 1'b1, 32'd0, 32'hCAFE_F00D);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst.async", bus.instruction, 32'h0020_81B3);
        @(posedge clk); #1;
        bus.address = 32'd0;
        #1;
        checkOutput("rst.blockWe", bus.instruction, 32'h0050_0093);
        bus.we = 1'b0;
        #2 rst = 1'b0;

        // Combinational follow with no clock edge in between.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            bus.address = randAddr();
            #1;
            checkFetch($sformatf("comb%0d", i));
        end

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            a  = randAddr();
            w  = ($urandom_range(0, 1) == 1);
            wa = ($urandom_range(0, 3) == 0) ? randAddr() : (randAddr() & 32'h0000_00FC);
            wd = $urandom;
            if ($urandom_range(0, 9) == 0) a = wa;
            applyStimulus(a, w, wa, wd);
            #1;
            checkFetch($sformatf("rnd%0d.pre", n));
            @(posedge clk); #1;
            modelWrite(w, wa, wd);
            checkFetch($sformatf("rnd%0d.post", n));
            if ($urandom_range(0, 24) == 0) begin
                bus.we = 1'b0;
                rst = 1'b1;
                #1;
                modelReset();
                checkFetch($sformatf("rnd%0d.rst", n));
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Word-addressed instruction memory for the single-cycle RV32I core.
- Fetch path is combinational, so the instruction for the current PC is valid in the same cycle.
- A clocked program port allows the bench or loader to overwrite words.
- Asynchronous reset restores a fixed default program image.

Parameters:
- DEPTH, 64, number of 32-bit instruction words.
- ADDR_W, 32, byte-address width of the fetch and write ports.
- DATA_W, 32, instruction word width.
- NOP_WORD, 32'h0000_0013, value returned for unmapped addresses (addi x0,x0,0).

Ports:
- clk  input  1  clock; program-port writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; restores the default image.
- address  input  ADDR_W  fetch byte address (PC).
- instruction  output  DATA_W  fetched word, combinational from address.
- we  input  1  program-port write enable.
- waddr  input  ADDR_W  program-port byte address.
- wdata  input  DATA_W  program-port write data.
- misaligned  output  1  high when address[1:0] != 0.
- out_of_range  output  1  high when address[ADDR_W-1:2] >= DEPTH.

Behaviour:
- Word index = address[ADDR_W-1:2]; bits [1:0] are ignored for the read.
- instruction = mem[index] when index < DEPTH, otherwise NOP_WORD.
- instruction is purely combinational: no latency, and it follows address changes within the same delta cycle.
- misaligned and out_of_range are combinational from address only. A misaligned address still returns the word at its index.
- Default image:
  - word0 (addr 0) 0x00500093
  - word1 (addr 4) 0x00A00113
  - word2 (addr 8) 0x002081B3
  - word3 (addr 12) 0x40110233
  - word4 (addr 16) 0x0020F2B3
  - word5 (addr 20) 0x0020E333
  - word6 (addr 24) 0x00302023
  - word7 (addr 28) 0x00000063
  - words 8..DEPTH-1 are NOP_WORD.
- Reset:
  - While rst=1, mem is forced to the default image asynchronously and immediately, with no clock needed.
  - instruction reflects the default image during reset.
  - rst dominates we; writes are blocked while rst=1.
- Write:
  - On posedge clk with rst=0, we=1, waddr[1:0]=0 and waddr[ADDR_W-1:2] < DEPTH: mem[waddr>>2] <= wdata.
  - Misaligned or out-of-range writes are silently dropped with no side effects.
- Read-during-write to the same word: instruction shows the old value until the clock edge, then the new value right after the edge.
- Without reset, power-up contents are undefined.
- Out-of-range wrap: there is none. Indices >= DEPTH always read NOP_WORD and never alias.

Decomposition:
- Package im_pkg holds DEPTH, NOP_WORD and the default-image constant array (DEFAULT_PROG, 8 entries). The core and the benches share these.
- No sub-module: a single flat module containing the memory array, the reset/write always block and the combinational read mux.

Test Plan:
- Pulse rst, then sweep address 0,4,...,28 at 10 ns steps -> instruction = 0x00500093, 0x00A00113, 0x002081B3, 0x40110233, 0x0020F2B3, 0x0020E333, 0x00302023, 0x00000063; misaligned=0 and out_of_range=0 throughout.
- address=32 -> 0x00000013. address=DEPTH*4=256 -> 0x00000013 with out_of_range=1. address=0xFFFF_FFFC -> NOP_WORD with out_of_range=1.
- address=9 -> instruction 0x002081B3, misaligned=1.
- we=1, waddr=8, wdata=0xDEADBEEF with address=8 -> 0x002081B3 before the edge and 0xDEADBEEF after it. Then waddr=10 or waddr=256 -> memory unchanged.
- After the write above, assert rst mid-cycle with no clock edge -> address 8 reads 0x002081B3 immediately. we=1 during rst -> no write occurs.
- Address changes with no clock activity -> instruction updates combinationally (checked at the #1 sample point).
